// File: rtl/weight_config_master_pkg.sv
// Shared definitions for the weight/bias configuration bus.
// Optional build macro: CFG_CHECKSUM_EN (adds a running checksum output).
package weight_config_master_pkg;

  // Width of every word on the config bus; neurons use the same width.
  localparam int CFG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WEIGHT = 3'd1,
    ST_BIAS   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } cfg_state_e;

endpackage : weight_config_master_pkg

// File: rtl/weight_config_master_cfg_counter.sv
// Loadable up-counter with a terminal-count flag (count == last_i).
// Used by weight_config_master for the weight index and the neuron index.
module weight_config_master_cfg_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next-count selection: load wins over increment.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == last_i);

endmodule : weight_config_master_cfg_counter

// File: rtl/weight_config_master.sv
// Transmitter of the neuron weight/bias configuration bus. One start loads
// one layer: per neuron, numWeights weight writes then one bias write.
// Optional build macro: CFG_CHECKSUM_EN adds output 'checksum', the wrapping
// sum of all words accepted for the current command.
module weight_config_master
  import weight_config_master_pkg::*;
#(
  parameter int maxNeurons = 32,
  parameter int maxWeights = 784
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CFG_WORD_W-1:0]             layerNum,
  input  logic [$clog2(maxNeurons+1)-1:0]   numNeurons,
  input  logic [$clog2(maxWeights+1)-1:0]   numWeights,
  input  logic [CFG_WORD_W-1:0]             s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              weightValid,
  output logic [CFG_WORD_W-1:0]             weightValue,
  output logic                              biasValid,
  output logic [CFG_WORD_W-1:0]             biasValue,
  output logic [CFG_WORD_W-1:0]             configLayerNum,
  output logic [CFG_WORD_W-1:0]             configNeuronNum,
  output logic                              busy,
  output logic                              done,
  output logic                              cfgErr
`ifdef CFG_CHECKSUM_EN
  ,
  output logic [CFG_WORD_W-1:0]             checksum
`endif
);

  localparam int NW = $clog2(maxNeurons + 1);
  localparam int WW = $clog2(maxWeights + 1);

  cfg_state_e             state_q;
  logic                   weightValid_q;
  logic                   biasValid_q;
  logic                   cfgErr_q;
  logic [CFG_WORD_W-1:0]  weightValue_q;
  logic [CFG_WORD_W-1:0]  biasValue_q;
  logic [CFG_WORD_W-1:0]  configLayerNum_q;
  logic [NW-1:0]          neuron_last_q;
  logic [WW-1:0]          weight_last_q;

  logic          accept;
  logic          start_ok;
  logic          start_go;
  logic [NW-1:0] neuron_cnt;
  logic          neuron_tc;
  logic [WW-1:0] weight_cnt;
  logic          weight_tc;

  // A command is legal only when both sizes are within 1..max.
  assign start_ok = (numNeurons != '0) && (numNeurons <= NW'(maxNeurons)) &&
                    (numWeights != '0) && (numWeights <= WW'(maxWeights));
  assign start_go = (state_q == ST_IDLE) && start && start_ok;

  assign s_ready  = (state_q == ST_WEIGHT) || (state_q == ST_BIAS);
  assign accept   = s_valid && s_ready;

  // Weight index: restarts at every legal start and at every neuron boundary.
  weight_config_master_cfg_counter #(.W(WW)) u_weight_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go || (state_q == ST_NEXT)),
    .load_val_i ('0),
    .inc_i      ((state_q == ST_WEIGHT) && accept),
    .last_i     (weight_last_q),
    .count_o    (weight_cnt),
    .tc_o       (weight_tc)
  );

  // Neuron index: doubles as configNeuronNum; advances only in NEXT so it
  // never moves in a strobe cycle.
  weight_config_master_cfg_counter #(.W(NW)) u_neuron_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .load_val_i ('0),
    .inc_i      ((state_q == ST_NEXT) && !neuron_tc),
    .last_i     (neuron_last_q),
    .count_o    (neuron_cnt),
    .tc_o       (neuron_tc)
  );

  // Command FSM with registered strobes, data and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      weightValid_q    <= 1'b0;
      biasValid_q      <= 1'b0;
      cfgErr_q         <= 1'b0;
      weightValue_q    <= '0;
      biasValue_q      <= '0;
      configLayerNum_q <= '0;
      neuron_last_q    <= '0;
      weight_last_q    <= '0;
    end else begin
      weightValid_q <= 1'b0;
      biasValid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              configLayerNum_q <= layerNum;
              neuron_last_q    <= numNeurons - NW'(1);
              weight_last_q    <= numWeights - WW'(1);
              cfgErr_q         <= 1'b0;
              state_q          <= ST_WEIGHT;
            end else begin
              cfgErr_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_WEIGHT: begin
          if (accept) begin
            weightValid_q <= 1'b1;
            weightValue_q <= s_data;
            if (weight_tc) begin
              state_q <= ST_BIAS;
            end
          end
        end
        ST_BIAS: begin
          if (accept) begin
            biasValid_q <= 1'b1;
            biasValue_q <= s_data;
            state_q     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          state_q <= neuron_tc ? ST_DONE : ST_WEIGHT;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [CFG_WORD_W-1:0] checksum_q;

  // Wrapping sum of accepted words, cleared by each legal start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (start_go) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + s_data;
    end
  end

  assign checksum = checksum_q;
`endif

  assign weightValid     = weightValid_q;
  assign weightValue     = weightValue_q;
  assign biasValid       = biasValid_q;
  assign biasValue       = biasValue_q;
  assign configLayerNum  = configLayerNum_q;
  assign configNeuronNum = CFG_WORD_W'(neuron_cnt);
  assign cfgErr          = cfgErr_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);

endmodule : weight_config_master

// File: tb/tb_weight_config_master.sv
// Self-checking bench for weight_config_master. Expected bus traffic is
// derived from the word stream fed in: word i of a command belongs to neuron
// i/(numWeights+1) and is the bias when i%(numWeights+1)==numWeights.
module tb_weight_config_master;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] layerNum;
  logic [5:0]  numNeurons;
  logic [9:0]  numWeights;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic [31:0] configLayerNum;
  logic [31:0] configNeuronNum;
  logic        busy;
  logic        done;
  logic        cfgErr;
`ifdef CFG_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  weight_config_master dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .layerNum        (layerNum),
    .numNeurons      (numNeurons),
    .numWeights      (numWeights),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .weightValid     (weightValid),
    .weightValue     (weightValue),
    .biasValid       (biasValid),
    .biasValue       (biasValue),
    .configLayerNum  (configLayerNum),
    .configNeuronNum (configNeuronNum),
    .busy            (busy),
    .done            (done),
    .cfgErr          (cfgErr)
`ifdef CFG_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 32'({weightValid, biasValid, done, busy, cfgErr, s_ready}), 32'd0);
    check({tag, "_wval"},    weightValue, 32'd0);
    check({tag, "_bval"},    biasValue, 32'd0);
    check({tag, "_layer"},   configLayerNum, 32'd0);
    check({tag, "_neuron"},  configNeuronNum, 32'd0);
`ifdef CFG_CHECKSUM_EN
    check({tag, "_csum"},    checksum, 32'd0);
`endif
  endtask

  // Runs one legal command. mode: 0 = s_valid always 1, 1 = toggle 1,0,1,0,
  // 2 = random. Called and returns at 1 time unit after a rising edge.
  task automatic run_cmd(input logic [31:0] layer, input int nn, input int nw,
                         input int mode, input bit seq, input bit busy_start);
    logic [31:0] words[$];
    logic [31:0] sum;
    int total, feed, obs, cyc, last_acc, exp_n;
    bit acc_prev, seen_done, is_bias;
    total = nn * (nw + 1);
    sum = 32'd0;
    for (int i = 0; i < total; i++) begin
      words.push_back(seq ? 32'(i + 1) : $urandom());
      sum += words[i];
    end
    layerNum   = layer;
    numNeurons = 6'(nn);
    numWeights = 10'(nw);
    start      = 1'b1;
    s_valid    = 1'b0;
    s_data     = $urandom();
    feed = 0; obs = 0; cyc = 0; last_acc = 0;
    acc_prev = 1'b0; seen_done = 1'b0;
    while (!seen_done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("cfgerr_cleared", 32'(cfgErr), 32'd0);
      end
      if (busy_start && cyc == 3) begin
        start = 1'b1; layerNum = 32'd5;
      end else if (busy_start && cyc == 4) begin
        start = 1'b0; layerNum = layer;
      end
      if (weightValid && biasValid) check("strobe_overlap", 32'd2, 32'd1);
      if (weightValid || biasValid) begin
        check("strobe_after_accept", 32'(acc_prev), 32'd1);
        if (obs < total) begin
          is_bias = (obs % (nw + 1)) == nw;
          exp_n   = obs / (nw + 1);
          check("weight_valid", 32'(weightValid), 32'(!is_bias));
          check("bias_valid",   32'(biasValid),   32'(is_bias));
          check(is_bias ? "bias_value" : "weight_value",
                is_bias ? biasValue : weightValue, words[obs]);
          check("neuron_num", configNeuronNum, 32'(exp_n));
          check("layer_num",  configLayerNum, layer);
        end else begin
          check("extra_strobe", 32'(obs + 1), 32'(total));
        end
        obs++;
      end else if (acc_prev) begin
        check("missing_strobe", 32'(weightValid | biasValid), 32'd1);
      end
      if (done) begin
        seen_done = 1'b1;
        check("words_written", 32'(obs), 32'(total));
        check("words_taken",   32'(feed), 32'(total));
        check("done_after_bias", 32'(cyc - last_acc), 32'd2);
        check("done_cfgerr", 32'(cfgErr), 32'd0);
        if (mode == 0) check("cycles_to_done", 32'(cyc + 1), 32'(nn * (nw + 2) + 2));
`ifdef CFG_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
        s_valid = 1'b0;
      end else begin
        check("busy_high", 32'(busy), 32'd1);
        case (mode)
          0:       s_valid = 1'b1;
          1:       s_valid = (cyc % 2) == 1;
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        s_data   = (s_valid && feed < total) ? words[feed] : $urandom();
        acc_prev = s_valid && s_ready;
        if (acc_prev) begin
          feed++;
          last_acc = cyc;
        end
      end
    end
    if (!seen_done) check("done_timeout", 32'(cyc), 32'd0);
    @(posedge clk); #1;
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_done",  32'(done), 32'd0);
    check("idle_ready", 32'(s_ready), 32'd0);
    check("idle_layer", configLayerNum, layer);
  endtask

  // Issues one illegal command with s_valid held high.
  task automatic run_illegal(input int nn, input int nw);
    logic [31:0] layer_before;
    layer_before = configLayerNum;
    layerNum   = 32'h77;
    numNeurons = 6'(nn);
    numWeights = 10'(nw);
    start      = 1'b1;
    s_valid    = 1'b1;
    s_data     = $urandom();
    @(posedge clk); #1;
    start = 1'b0;
    check("ill_done",    32'(done), 32'd1);
    check("ill_cfgerr",  32'(cfgErr), 32'd1);
    check("ill_ready",   32'(s_ready), 32'd0);
    check("ill_strobes", 32'({weightValid, biasValid}), 32'd0);
    check("ill_layer",   configLayerNum, layer_before);
    @(posedge clk); #1;
    check("ill_done_end", 32'(done), 32'd0);
    check("ill_busy_end", 32'(busy), 32'd0);
    check("ill_sticky",   32'(cfgErr), 32'd1);
    check("ill_strobes2", 32'({weightValid, biasValid}), 32'd0);
    s_valid = 1'b0;
  endtask

  initial begin
    int wcnt;
    rst = 1'b1; start = 1'b0; layerNum = '0; numNeurons = '0; numWeights = '0;
    s_data = '0; s_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // Small layer, stream always valid, sequential words 1..8.
    run_cmd(32'd1, 2, 3, 0, 1'b1, 1'b0);
    // Same command under 1,0,1,0 backpressure.
    run_cmd(32'd1, 2, 3, 1, 1'b1, 1'b0);
    // Illegal commands, each followed by legal ones.
    run_illegal(2, 0);
    run_cmd(32'd7, 3, 2, 2, 1'b0, 1'b0);
    run_illegal(33, 3);
    run_illegal(0, 3);
    run_cmd(32'd8, 1, 1, 0, 1'b0, 1'b0);
    // Start while busy must be ignored.
    run_cmd(32'd2, 2, 4, 0, 1'b0, 1'b1);

    // Reset in the middle of a load.
    layerNum = 32'd9; numNeurons = 6'd2; numWeights = 10'd4;
    start = 1'b1; s_valid = 1'b1; s_data = $urandom();
    wcnt = 0;
    for (int i = 0; i < 20 && wcnt < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (weightValid) wcnt++;
      s_data = $urandom();
    end
    check("midload_weights_seen", 32'(wcnt), 32'd2);
    rst = 1'b1;
    #1;
    check_all_zero("midload_reset");
    s_valid = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmd(32'd3, 2, 3, 0, 1'b1, 1'b0);

    // Randomized commands with random stream gaps.
    for (int k = 0; k < 6; k++) begin
      run_cmd($urandom(), int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 2, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_weight_config_master
